// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg: shared FSM/detector state types and default word width for the bit scanner
package bit_scan_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} fsm_t;
  typedef enum logic [1:0] {DET_A = 2'b00, DET_B = 2'b01, DET_C = 2'b10, DET_D = 2'b11} det_t;
endpackage

// File: rtl/seq110_det.sv
// seq110_det: Mealy detector flagging a 0 that follows exactly two consecutive 1s
module seq110_det
  import bit_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic inp,
  output logic outp
);
  det_t state_q, state_d;
  always_comb begin
    state_d = clr ? DET_A :
              !en ? state_q :
              !inp ? DET_A :
              state_q == DET_A ? DET_B :
              state_q == DET_B ? DET_C : DET_D;
    outp = en & ~inp & (state_q == DET_C);
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= DET_A;
    else     state_q <= state_d;
  end
endmodule

// File: rtl/bit_scan_ctrl.sv
// bit_scan_ctrl: shifts a word MSB first through a 110 detector and reports the match count; define BIT_SCAN_CONT_EN to carry detector state across words
module bit_scan_ctrl
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             match_any
);
  localparam int BW = $clog2(WIDTH + 1);
  fsm_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept, shifting, hit, clr;
  assign in_ready  = state_q == IDLE;
  assign busy      = ~in_ready;
  assign done      = state_q == REPORT;
  assign match_cnt = cnt_q;
  assign match_any = |cnt_q;
  assign accept    = in_valid & in_ready;
  assign shifting  = state_q == SHIFT;
`ifdef BIT_SCAN_CONT_EN
  assign clr = 1'b0;
`else
  assign clr = accept;
`endif
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? SHIFT : IDLE) :
              state_q == SHIFT ? (bit_q == BW'(WIDTH - 1) ? REPORT : SHIFT) : IDLE;
    sr_d    = accept ? in_data : shifting ? sr_q << 1 : sr_q;
    bit_d   = accept ? '0 : shifting ? bit_q + BW'(1) : bit_q;
    cnt_d   = accept ? '0 : hit ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end
  seq110_det u_det (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (shifting),
    .inp (sr_q[WIDTH-1]),
    .outp(hit)
  );
endmodule

// File: tb/tb_bit_scan_ctrl.sv
// tb_bit_scan_ctrl: directed and random checks of bit_scan_ctrl against a run-length model
module tb_bit_scan_ctrl;
  localparam int W = 8;
  localparam int CW = $clog2(W + 1);
`ifdef BIT_SCAN_CONT_EN
  localparam int CONT_EXP = 1;
`else
  localparam int CONT_EXP = 0;
`endif
  logic clk = 0, rst, in_valid;
  logic [W-1:0] in_data;
  logic in_ready, busy, done, match_any;
  logic [CW-1:0] match_cnt;
  int tests = 0, fails = 0;
  int phase = 0, exp_cnt = 0, pend = 0, run = 0;
  always #5 clk = ~clk;
  bit_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .done(done), .match_cnt(match_cnt), .match_any(match_any)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // pattern count from the 1-run length preceding each 0, MSB first
  task automatic count_word(input logic [W-1:0] d);
`ifndef BIT_SCAN_CONT_EN
    run = 0;
`endif
    pend = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) run++;
      else begin
        if (run == 2) pend++;
        run = 0;
      end
    end
  endtask
  task automatic step(input logic v, input logic [W-1:0] d);
    chk("in_ready", in_ready, phase == 0);
    chk("busy", busy, phase != 0);
    chk("done", done, phase == W + 1);
    if (phase == 0 || phase == W + 1) begin
      chk("match_cnt", match_cnt, exp_cnt);
      chk("match_any", match_any, exp_cnt != 0);
    end
    in_valid = v;
    in_data = d;
    @(posedge clk); #1;
    if (phase == 0) begin
      if (v) begin
        count_word(d);
        phase = 1;
      end
    end else if (phase == W + 1) phase = 0;
    else begin
      phase++;
      if (phase == W + 1) exp_cnt = pend;
    end
  endtask
  task automatic do_reset(input int n);
    rst = 1;
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 0;
    phase = 0;
    exp_cnt = 0;
    run = 0;
  endtask
  task automatic scan(input string tag, input logic [W-1:0] d, input int exp);
    step(1'b1, d);
    repeat (W) step(1'b0, W'($urandom));
    chk(tag, match_cnt, exp);
    step(1'b0, '0);
  endtask
  initial begin
    rst = 1;
    in_valid = 0;
    in_data = '0;
    do_reset(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_match_any", match_any, 0);
    step(1'b0, '0);
    scan("w11011000", 8'b11011000, 2);
    chk("w11011000_any", match_any, 1);
    scan("w11100000", 8'b11100000, 0);
    scan("w00000011", 8'b00000011, 0);
    scan("span_w00000000", 8'b00000000, CONT_EXP);
    step(1'b1, 8'b11011000);
    repeat (3) step(1'b0, '0);
    chk("mid_busy", busy, 1);
    do_reset(1);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_match_cnt", match_cnt, 0);
    repeat (W + 3) step(1'b0, '0);
    repeat (6 * (W + 2)) step(1'b1, W'($urandom));
    repeat (400) step(1'($urandom_range(0, 1)), W'($urandom));
    repeat (W + 2) step(1'b0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
